vga_timing_gen: RTL and testbench

- Parametrised raster timing generator, successor to the fixed 640x480 timing block.
- Produces HS/VS with selectable polarity, active-video flag, x/y coordinates and a linear framebuffer address.
- Adds a pixel-clock enable, line/frame strobes and a vblank flag.
- Sits between the pixel clock domain and the framebuffer read and colour-output logic.

---
 rtl/vga_pkg.sv | 37 +++
 rtl/vga_axis_counter.sv | 64 ++++++
 rtl/vga_timing_gen.sv | 207 ++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the raster timing generator:
//   - sync polarity constants
//   - a timing tuple holding the eight horizontal/vertical period values
//   - the default 640x480@60 timing (25.175 MHz pixel clock)
//   - axis_total(): sum of one axis' periods
// -----------------------------------------------------------------------------
package vga_pkg;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  typedef struct packed {
    int unsigned h_act;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_act;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480_60 = '{
    h_act:  640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_act:  480, v_fp: 10, v_sync:  2, v_bp: 33
  };

  function automatic int unsigned axis_total(input int unsigned act,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One raster axis (horizontal or vertical). Counts 0..TOTAL-1 and wraps, with
// the period order sync, back porch, active, front porch. Decodes are taken
// from the *next* count so the parent can register them in step with it.
//
// Ports:
//   clock, reset_n   pixel clock, async active-low reset (count -> 0)
//   advance          step the counter this cycle
//   count_next       value the counter takes at the coming edge
//   carry            advance while at TOTAL-1 (the counter wraps to 0)
//   in_sync_next     count_next is inside the sync period
//   in_act_next      count_next is inside the active window
//   offset_next      count_next - (SYNC+BP); meaningful when in_act_next
// -----------------------------------------------------------------------------
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned ACT  = 640,
  parameter int unsigned FP   = 16,
  parameter int unsigned SYNC = 96,
  parameter int unsigned BP   = 48,
  parameter int unsigned W    = 12
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         advance,
  output logic [W-1:0] count_next,
  output logic         carry,
  output logic         in_sync_next,
  output logic         in_act_next,
  output logic [W-1:0] offset_next
);

  localparam int unsigned TOTAL = axis_total(ACT, FP, SYNC, BP);
  localparam int unsigned START = SYNC + BP;

  logic [W-1:0] count;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering in simulation.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  always_comb begin
    carry      = advance && (count == W'(TOTAL - 1));
    count_next = count;
    if (carry) begin
      count_next = '0;
    end else if (advance) begin
      count_next = count + W'(1);
    end
  end

  assign in_sync_next = (count_next < W'(SYNC));
  assign in_act_next  = (count_next >= W'(START)) && (count_next < W'(START + ACT));
  assign offset_next  = count_next - W'(START);

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised raster timing generator. All outputs are registered from the
// next counter values, so they describe the same h/v position the counters
// hold in that cycle. State advances only on cycles with enable high.
//
// Optional build macro VGA_TIMING_SCALE2_EN: x/y report half resolution and
// pixel addresses an (H_ACT/2)x(V_ACT/2) buffer, each source pixel repeated
// twice horizontally and each source row scanned twice.
//
// Ports:
//   clock, reset_n  pixel clock, async active-low reset
//   enable          pixel-clock enable
//   hs, vs          syncs, at HS_POL/VS_POL level while in the sync period
//   active          position is in the visible area
//   vblank          line is outside the vertical active band
//   line_start      one-enabled-cycle strobe at h=0
//   frame_start     one-enabled-cycle strobe at h=0, v=0
//   x, y            active column/row (0 outside the visible area/band)
//   pixel           linear framebuffer address, held across blanking
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACT   = VGA_640X480_60.h_act,
  parameter int unsigned H_FP    = VGA_640X480_60.h_fp,
  parameter int unsigned H_SYNC  = VGA_640X480_60.h_sync,
  parameter int unsigned H_BP    = VGA_640X480_60.h_bp,
  parameter int unsigned V_ACT   = VGA_640X480_60.v_act,
  parameter int unsigned V_FP    = VGA_640X480_60.v_fp,
  parameter int unsigned V_SYNC  = VGA_640X480_60.v_sync,
  parameter int unsigned V_BP    = VGA_640X480_60.v_bp,
  parameter bit          HS_POL  = SYNC_ACTIVE_LOW,
  parameter bit          VS_POL  = SYNC_ACTIVE_LOW,
  parameter int unsigned COORD_W = 12,
  parameter int unsigned ADDR_W  = 19
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  output logic               hs,
  output logic               vs,
  output logic               active,
  output logic               vblank,
  output logic               line_start,
  output logic               frame_start,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [ADDR_W-1:0]  pixel
);

  localparam int unsigned H_TOTAL = axis_total(H_ACT, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = axis_total(V_ACT, V_FP, V_SYNC, V_BP);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (H_ACT == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACT == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_period
    $error("vga_timing_gen: every timing period must be non-zero");
  end
  if (64'(H_TOTAL) > (64'd1 << COORD_W) ||
      64'(V_TOTAL) > (64'd1 << COORD_W)) begin : g_bad_coord_w
    $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in COORD_W bits");
  end
  if (64'(H_ACT) * 64'(V_ACT) > (64'd1 << ADDR_W)) begin : g_bad_addr_w
    $error("vga_timing_gen: H_ACT*V_ACT does not fit in ADDR_W bits");
  end
`ifdef VGA_TIMING_SCALE2_EN
  if ((H_ACT % 2) != 0 || (V_ACT % 2) != 0) begin : g_bad_scale2
    $error("vga_timing_gen: half-resolution mode needs even H_ACT and V_ACT");
  end
`endif

  // ---------------------------------------------------------------------------
  // Axis counters; the vertical axis steps on the horizontal wrap
  // ---------------------------------------------------------------------------
  logic [COORD_W-1:0] h_next, h_off_next, v_next, v_off_next;
  logic               h_carry, h_sync_next, h_act_next;
  logic               v_carry, v_sync_next, v_act_next;

  vga_axis_counter #(
    .ACT (H_ACT), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP), .W (COORD_W)
  ) u_h_axis (
    .clock        (clock),
    .reset_n      (reset_n),
    .advance      (enable),
    .count_next   (h_next),
    .carry        (h_carry),
    .in_sync_next (h_sync_next),
    .in_act_next  (h_act_next),
    .offset_next  (h_off_next)
  );

  vga_axis_counter #(
    .ACT (V_ACT), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP), .W (COORD_W)
  ) u_v_axis (
    .clock        (clock),
    .reset_n      (reset_n),
    .advance      (h_carry),
    .count_next   (v_next),
    .carry        (v_carry),
    .in_sync_next (v_sync_next),
    .in_act_next  (v_act_next),
    .offset_next  (v_off_next)
  );

  // Wrapping into h=0 is the only way to reach it after reset, so the carries
  // double as the strobe conditions.
  logic line_start_next, frame_start_next, active_next;
  assign line_start_next  = h_carry;
  assign frame_start_next = h_carry && v_carry;
  assign active_next      = h_act_next && v_act_next;

  // Full-resolution coordinates of the current position (0 outside).
  logic [COORD_W-1:0] x_pos, y_pos;

  // ---------------------------------------------------------------------------
  // Pixel address: running counter, no multiplier
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] pixel_next;

`ifdef VGA_TIMING_SCALE2_EN
  logic [ADDR_W-1:0] line_base, line_base_next;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pixel_next     = pixel;
    line_base_next = line_base;
    if (frame_start_next) begin
      pixel_next     = '0;
      line_base_next = '0;
    end else if (active && x_pos[0]) begin
      // Each source pixel spans two columns; step after the second one.
      if (x_pos == COORD_W'(H_ACT - 1)) begin
        if (!y_pos[0]) begin
          // First of the two scans of a source row: replay it.
          pixel_next = line_base;
        end else begin
          pixel_next     = pixel + ADDR_W'(1);
          line_base_next = pixel + ADDR_W'(1);
        end
      end else begin
        pixel_next = pixel + ADDR_W'(1);
      end
    end
  end

  assign x = {1'b0, x_pos[COORD_W-1:1]};
  assign y = {1'b0, y_pos[COORD_W-1:1]};
`else
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pixel_next = pixel;
    if (frame_start_next) begin
      pixel_next = '0;
    end else if (active) begin
      pixel_next = pixel + ADDR_W'(1);
    end
  end

  assign x = x_pos;
  assign y = y_pos;
`endif

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  // NOTE: only control/datapath registers exist here; all of them take the
  // asynchronous reset so outputs are valid the moment reset_n falls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hs          <= HS_POL;
      vs          <= VS_POL;
      active      <= 1'b0;
      vblank      <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      x_pos       <= '0;
      y_pos       <= '0;
      pixel       <= '0;
`ifdef VGA_TIMING_SCALE2_EN
      line_base   <= '0;
`endif
    end else if (enable) begin
      hs          <= h_sync_next ? HS_POL : ~HS_POL;
      vs          <= v_sync_next ? VS_POL : ~VS_POL;
      active      <= active_next;
      vblank      <= ~v_act_next;
      line_start  <= line_start_next;
      frame_start <= frame_start_next;
      x_pos       <= active_next ? h_off_next : '0;
      y_pos       <= v_act_next  ? v_off_next : '0;
      pixel       <= pixel_next;
`ifdef VGA_TIMING_SCALE2_EN
      line_base   <= line_base_next;
`endif
    end else begin
      // Strobes last one enabled cycle; a stalled cycle clears them.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Three generators share one clock:
//   dut 0  default 640x480 timing, enable held high
//   dut 1  small 16x6 timing, random enable, asynchronous reset mid-frame
//   dut 2  tiny 4x3 timing, high-polarity syncs, enable later alternating
// Expected outputs come from a positional model: the number of enabled edges
// since reset gives the raster position directly by division/modulo.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  typedef struct {
    int ha, hf, hsw, hb, va, vf, vsw, vb;
    bit hp, vp;
  } cfg_t;

  typedef struct {
    logic        hs, vs, active, vblank, ls, fs;
    logic [31:0] x, y, pixel;
  } obs_t;

`ifdef VGA_TIMING_SCALE2_EN
  localparam int C_VA = 4;
`else
  localparam int C_VA = 3;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst_n [3];
  logic en    [3];

  logic        a_hs, a_vs, a_act, a_vb, a_ls, a_fs;
  logic [11:0] a_x, a_y;
  logic [18:0] a_pix;
  logic        b_hs, b_vs, b_act, b_vb, b_ls, b_fs;
  logic [7:0]  b_x, b_y;
  logic [9:0]  b_pix;
  logic        c_hs, c_vs, c_act, c_vb, c_ls, c_fs;
  logic [7:0]  c_x, c_y;
  logic [7:0]  c_pix;

  vga_timing_gen u_dut_a (
    .clock (clock), .reset_n (rst_n[0]), .enable (en[0]),
    .hs (a_hs), .vs (a_vs), .active (a_act), .vblank (a_vb),
    .line_start (a_ls), .frame_start (a_fs), .x (a_x), .y (a_y), .pixel (a_pix)
  );

  vga_timing_gen #(
    .H_ACT (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACT (6),  .V_FP (1), .V_SYNC (2), .V_BP (2),
    .HS_POL (1'b0), .VS_POL (1'b0), .COORD_W (8), .ADDR_W (10)
  ) u_dut_b (
    .clock (clock), .reset_n (rst_n[1]), .enable (en[1]),
    .hs (b_hs), .vs (b_vs), .active (b_act), .vblank (b_vb),
    .line_start (b_ls), .frame_start (b_fs), .x (b_x), .y (b_y), .pixel (b_pix)
  );

  vga_timing_gen #(
    .H_ACT (4),    .H_FP (1), .H_SYNC (1), .H_BP (1),
    .V_ACT (C_VA), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .HS_POL (1'b1), .VS_POL (1'b1), .COORD_W (8), .ADDR_W (8)
  ) u_dut_c (
    .clock (clock), .reset_n (rst_n[2]), .enable (en[2]),
    .hs (c_hs), .vs (c_vs), .active (c_act), .vblank (c_vb),
    .line_start (c_ls), .frame_start (c_fs), .x (c_x), .y (c_y), .pixel (c_pix)
  );

  cfg_t cfg     [3];
  int   t       [3];   // enabled edges since reset
  bit   last_en [3];   // enable seen at the most recent edge
  int   maxp    [3];   // highest pixel seen while active this frame
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Directed-check bookkeeping
  int a_ls_cyc = -1, a_hs_low = 0, a_ls_checks = 0;
  bit a_vs_rose = 0, a_seen_act = 0;
  bit b_after_rst = 0;
  bit alt_phase = 0;
  int c_fs_cyc = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int htot(input cfg_t c);
    return c.ha + c.hf + c.hsw + c.hb;
  endfunction

  function automatic int ftot(input cfg_t c);
    return htot(c) * (c.va + c.vf + c.vsw + c.vb);
  endfunction

  function automatic int last_pixel(input cfg_t c);
`ifdef VGA_TIMING_SCALE2_EN
    return (c.ha / 2) * (c.va / 2) - 1;
`else
    return c.ha * c.va - 1;
`endif
  endfunction

  // Position-based reference: raster position from the enabled-edge count.
  function automatic obs_t model(input cfg_t c, input int tt, input bit en_edge);
    obs_t e;
    int   h, v, hst, vst, xf, yf;
    bit   hband, vband;
    h     = tt % htot(c);
    v     = (tt / htot(c)) % (c.va + c.vf + c.vsw + c.vb);
    hst   = c.hsw + c.hb;
    vst   = c.vsw + c.vb;
    hband = (h >= hst) && (h < hst + c.ha);
    vband = (v >= vst) && (v < vst + c.va);
    xf    = (hband && vband) ? h - hst : 0;
    yf    = vband ? v - vst : 0;
    e.hs     = (h < c.hsw) ? c.hp : !c.hp;
    e.vs     = (v < c.vsw) ? c.vp : !c.vp;
    e.active = hband && vband;
    e.vblank = !vband;
    e.ls     = en_edge && (tt > 0) && (h == 0);
    e.fs     = e.ls && (v == 0);
`ifdef VGA_TIMING_SCALE2_EN
    e.x     = 32'(xf / 2);
    e.y     = 32'(yf / 2);
    e.pixel = 32'((yf / 2) * (c.ha / 2) + xf / 2);
`else
    e.x     = 32'(xf);
    e.y     = 32'(yf);
    e.pixel = 32'(yf * c.ha + xf);
`endif
    return e;
  endfunction

  task automatic get_obs(input int i, output obs_t o);
    case (i)
      0: begin
        o.hs = a_hs; o.vs = a_vs; o.active = a_act; o.vblank = a_vb;
        o.ls = a_ls; o.fs = a_fs; o.x = 32'(a_x); o.y = 32'(a_y); o.pixel = 32'(a_pix);
      end
      1: begin
        o.hs = b_hs; o.vs = b_vs; o.active = b_act; o.vblank = b_vb;
        o.ls = b_ls; o.fs = b_fs; o.x = 32'(b_x); o.y = 32'(b_y); o.pixel = 32'(b_pix);
      end
      default: begin
        o.hs = c_hs; o.vs = c_vs; o.active = c_act; o.vblank = c_vb;
        o.ls = c_ls; o.fs = c_fs; o.x = 32'(c_x); o.y = 32'(c_y); o.pixel = 32'(c_pix);
      end
    endcase
  endtask

  task automatic compare(input int i);
    obs_t o, e;
    get_obs(i, o);
    e = model(cfg[i], t[i], last_en[i]);
    check($sformatf("hs[%0d]", i),          32'(o.hs),     32'(e.hs));
    check($sformatf("vs[%0d]", i),          32'(o.vs),     32'(e.vs));
    check($sformatf("active[%0d]", i),      32'(o.active), 32'(e.active));
    check($sformatf("vblank[%0d]", i),      32'(o.vblank), 32'(e.vblank));
    check($sformatf("line_start[%0d]", i),  32'(o.ls),     32'(e.ls));
    check($sformatf("frame_start[%0d]", i), 32'(o.fs),     32'(e.fs));
    check($sformatf("x[%0d]", i),           o.x,           e.x);
    check($sformatf("y[%0d]", i),           o.y,           e.y);
    if (e.active) check($sformatf("pixel[%0d]", i), o.pixel, e.pixel);
  endtask

  task automatic track();
    // dut 0: line period, hs width, vs width, first visible pixel
    if (a_ls === 1'b1) begin
      if (a_ls_cyc >= 0 && a_ls_checks < 3) begin
        check("a_line_period", 32'(cyc - a_ls_cyc), 32'd800);
        check("a_hs_low_per_line", 32'(a_hs_low), 32'd96);
        a_ls_checks++;
      end
      a_ls_cyc = cyc;
      a_hs_low = 0;
    end
    if (a_hs === 1'b0) a_hs_low++;
    if (!a_vs_rose && a_vs === 1'b1) begin
      a_vs_rose = 1;
      check("a_vs_low_span", 32'(t[0]), 32'd1600);
    end
    if (!a_seen_act && a_act === 1'b1) begin
      a_seen_act = 1;
      check("a_first_active_pos", 32'(t[0]), 32'(35 * 800 + 144));
      check("a_first_x", 32'(a_x), 32'd0);
      check("a_first_y", 32'(a_y), 32'd0);
      check("a_first_pixel", 32'(a_pix), 32'd0);
    end
    // dut 1/2: last pixel address of each frame
    if (b_act === 1'b1 && int'(b_pix) > maxp[1]) maxp[1] = int'(b_pix);
    if (c_act === 1'b1 && int'(c_pix) > maxp[2]) maxp[2] = int'(c_pix);
    if (b_fs === 1'b1) begin
      check("b_frame_last_pixel", 32'(maxp[1]), 32'(last_pixel(cfg[1])));
      maxp[1] = -1;
      if (b_after_rst) begin
        check("b_first_frame_after_reset", 32'(t[1]), 32'(ftot(cfg[1])));
        b_after_rst = 0;
      end
    end
    if (c_fs === 1'b1) begin
      check("c_frame_last_pixel", 32'(maxp[2]), 32'(last_pixel(cfg[2])));
      maxp[2] = -1;
      if (alt_phase) begin
        if (c_fs_cyc >= 0) check("c_frame_period_alt", 32'(cyc - c_fs_cyc), 32'(2 * ftot(cfg[2])));
        c_fs_cyc = cyc;
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n[i]) begin
        t[i]       = 0;
        last_en[i] = 1'b0;
        maxp[i]    = -1;
      end else begin
        last_en[i] = en[i];
        if (en[i]) t[i]++;
      end
      compare(i);
    end
    track();
  endtask

  initial begin
    cfg[0] = '{ha: 640, hf: 16, hsw: 96, hb: 48, va: 480, vf: 10, vsw: 2, vb: 33, hp: 1'b0, vp: 1'b0};
    cfg[1] = '{ha: 16,  hf: 2,  hsw: 3,  hb: 3,  va: 6,   vf: 1,  vsw: 2, vb: 2,  hp: 1'b0, vp: 1'b0};
    cfg[2] = '{ha: 4,   hf: 1,  hsw: 1,  hb: 1,  va: C_VA, vf: 1, vsw: 1, vb: 1,  hp: 1'b1, vp: 1'b1};
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0;
      en[i]    = 1'b0;
      t[i]     = 0;
      last_en[i] = 1'b0;
      maxp[i]  = -1;
    end

    // Reset state, then release
    for (int k = 0; k < 3; k++) step();
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

    // Phase 1: dut0/dut2 free-running, dut1 random enable with a mid-frame reset
    for (int k = 0; k < 28300; k++) begin
      en[0] = 1'b1;
      en[1] = ($urandom % 4) != 0;
      en[2] = 1'b1;
      step();
      if (k == 5000) begin
        #3;
        rst_n[1] = 1'b0;
        #1;
        t[1] = 0;
        last_en[1] = 1'b0;
        maxp[1] = -1;
        compare(1);          // reset takes effect before the next edge
        step();
        step();
        rst_n[1] = 1'b1;
        b_after_rst = 1;
      end
    end

    // Phase 2: dut2 enable alternating 1/0
    alt_phase = 1;
    for (int k = 0; k < 2000; k++) begin
      en[0] = 1'b1;
      en[1] = ($urandom % 4) != 0;
      en[2] = k[0];
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
